// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants and types for the instruction fetch path.
package fetch_unit_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] NOP_INSTR = 16'hF000;
  localparam logic [WORD_W-1:0] PC_INC    = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding instruction word + its pc; head is combinational and
// reads as zero while empty.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head_entry,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  assign head_entry = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word fetch over a wait-handshake memory
// port into a prefetch FIFO, with redirect flushing buffered and in-flight words.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | re low, FIFO has no free slot for another word
//   REQ     | re high, address held until memory drops wait
//   GAP     | re low for one cycle so memory re-arms after capture/abort
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [WORD_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  input  logic              mem_wait_i,
  input  logic [WORD_W-1:0] mem_data_i,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] redirect_addr_i,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] fetch_pc_nxt;
  logic              capture;
  logic              push;
  logic              pop;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after_pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  assign mem_re_o        = (state == ST_REQ);
  assign mem_addr_o      = fetch_pc;
  assign capture         = mem_re_o && !mem_wait_i;
  assign push            = capture && !redirect_i;
  assign pop             = instr_valid_o && instr_ready_i;
  assign count_after_pop = count - CNT_W'(pop);
  assign push_entry      = '{instr: mem_data_i, pc: fetch_pc};

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      ST_IDLE: if (count < DEPTH_CNT) state_nxt = ST_REQ;
      ST_REQ: begin
        if (capture) begin
          state_nxt    = ST_GAP;
          fetch_pc_nxt = fetch_pc + PC_INC;
        end
      end
      // Only launch when a slot is guaranteed, so a capture never meets a full FIFO.
      ST_GAP:  state_nxt = (count_after_pop < DEPTH_CNT) ? ST_REQ : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (redirect_i) begin
      state_nxt    = ST_GAP;
      fetch_pc_nxt = align_pc(redirect_addr_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      fetch_pc <= align_pc(RESET_PC);
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_i),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .empty      (empty),
    .count      (count)
  );

  assign instr_valid_o = !empty;
  assign instr_o       = head_entry.instr;
  assign instr_pc_o    = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// scored against an in-order instruction-stream model.
module tb_fetch_unit;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr_o, mem_data_i, redirect_addr_i, instr_o, instr_pc_o;
  logic        mem_re_o, mem_wait_i, redirect_i, instr_valid_o, instr_ready_i;

  int n_cmp = 0;
  int n_err = 0;

  // memory responder state
  int need = 1;
  int need_fixed = 1;
  bit rand_wait = 1'b0;
  int re_cnt = 0;
  int cap_cnt = 0;
  int addr_err = 0;
  int gap_err = 0;
  logic        prev_re = 1'b0;
  logic        prev_end = 1'b0;
  logic [15:0] prev_addr = '0;

  logic [15:0] got_pc[$];
  logic [15:0] got_i[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_addr_o      (mem_addr_o),
    .mem_re_o        (mem_re_o),
    .mem_wait_i      (mem_wait_i),
    .mem_data_i      (mem_data_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i)
  );

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h0BB6;
    if (a == 16'h0002) return 16'h0102;
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory is ready only after `need` cycles of re high; re-arms on a low cycle.
  assign mem_wait_i = mem_re_o ? (re_cnt < need) : 1'b1;
  assign mem_data_i = (mem_re_o && !mem_wait_i) ? rom_word(mem_addr_o) : 16'hDEAD;

  always @(posedge clk) begin
    if (!rst && mem_re_o && !mem_wait_i) cap_cnt <= cap_cnt + 1;
    if (!rst && prev_re && mem_re_o && !prev_end && mem_addr_o != prev_addr) addr_err <= addr_err + 1;
    if (!rst && prev_end && mem_re_o) gap_err <= gap_err + 1;
    prev_re   <= mem_re_o;
    prev_addr <= mem_addr_o;
    prev_end  <= mem_re_o && (!mem_wait_i || redirect_i);
    re_cnt    <= mem_re_o ? re_cnt + 1 : 0;
    if (!mem_re_o) need <= rand_wait ? int'($urandom_range(1, 4)) : need_fixed;
  end

  task automatic hold_reset(input bit ready, input int nf);
    rst = 1'b1; redirect_i = 1'b0; redirect_addr_i = '0;
    instr_ready_i = ready; need_fixed = nf;
    repeat (2) @(posedge clk);
  endtask

  // Deassert after a posedge; returns #1 into cycle 0 (first REQ cycle).
  task automatic release_reset();
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Collect up to n accepted words (ready held high), starting at next negedge.
  task automatic collect(input int n, input int budget);
    got_pc.delete(); got_i.delete();
    instr_ready_i = 1'b1;
    for (int c = 0; c < budget && got_pc.size() < n; c++) begin
      @(negedge clk);
      if (instr_valid_o) begin got_pc.push_back(instr_pc_o); got_i.push_back(instr_o); end
    end
  endtask

  task automatic test_reset();
    hold_reset(1'b1, 1);
    @(negedge clk);
    n_cmp++; if (mem_re_o !== 1'b0) begin n_err++; $display("FAIL reset_re: got %b want 0", mem_re_o); end
    n_cmp++; if (mem_addr_o !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h want %h", mem_addr_o, RESET_PC); end
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
    n_cmp++; if (instr_o !== 16'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0000", instr_o); end
    n_cmp++; if (instr_pc_o !== 16'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0000", instr_pc_o); end
  endtask

  task automatic test_zero_wait();
    bit          e_re[6]    = '{1, 1, 0, 1, 1, 0};
    bit          e_val[6]   = '{0, 0, 1, 0, 0, 1};
    logic [15:0] e_addr[6]  = '{16'h0, 16'h0, 16'h0, 16'h2, 16'h2, 16'h0};
    logic [15:0] e_instr[6] = '{16'h0, 16'h0, 16'h0BB6, 16'h0, 16'h0, 16'h0102};
    logic [15:0] e_pc[6]    = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h2};
    @(posedge clk); hold_reset(1'b1, 1); release_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_re_o !== e_re[c]) begin n_err++; $display("FAIL zw_re c%0d: got %b want %b", c, mem_re_o, e_re[c]); end
      if (e_re[c]) begin
        n_cmp++; if (mem_addr_o !== e_addr[c]) begin n_err++; $display("FAIL zw_addr c%0d: got %h want %h", c, mem_addr_o, e_addr[c]); end
      end
      n_cmp++; if (instr_valid_o !== e_val[c]) begin n_err++; $display("FAIL zw_valid c%0d: got %b want %b", c, instr_valid_o, e_val[c]); end
      if (e_val[c]) begin
        n_cmp++; if (instr_o !== e_instr[c] || instr_pc_o !== e_pc[c]) begin n_err++;
          $display("FAIL zw_word c%0d: got %h@%h want %h@%h", c, instr_o, instr_pc_o, e_instr[c], e_pc[c]); end
      end
    end
  endtask

  task automatic test_ready_stall();
    int base;
    @(posedge clk); hold_reset(1'b0, 1); release_reset();
    base = cap_cnt;
    repeat (15) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (cap_cnt - base != DEPTH) begin n_err++; $display("FAIL stall_fetched: got %0d want %0d", cap_cnt - base, DEPTH); end
    n_cmp++; if (mem_re_o !== 1'b0) begin n_err++; $display("FAIL stall_idle_re: got %b want 0", mem_re_o); end
    n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'h0) begin n_err++;
      $display("FAIL stall_head: got v%b pc %h want v1 pc 0000", instr_valid_o, instr_pc_o); end
    got_pc.delete(); got_i.delete();
    instr_ready_i = 1'b1;
    for (int c = 0; c < 40 && got_pc.size() < 3; c++) begin
      if (instr_valid_o) begin got_pc.push_back(instr_pc_o); got_i.push_back(instr_o); end
      @(negedge clk);
    end
    n_cmp++; if (got_pc.size() != 3) begin n_err++; $display("FAIL stall_resume_count: got %0d want 3", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_cmp++; if (got_pc[i] !== 16'(2 * i) || got_i[i] !== rom_word(16'(2 * i))) begin n_err++;
        $display("FAIL stall_order %0d: got %h@%h want %h@%h", i, got_i[i], got_pc[i], rom_word(16'(2 * i)), 16'(2 * i)); end
    end
  endtask

  task automatic test_wait_states();
    @(posedge clk); hold_reset(1'b0, 5); release_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_re_o !== 1'b1 || mem_addr_o !== 16'h0) begin n_err++;
        $display("FAIL ws_hold c%0d: got re%b addr %h want re1 addr 0000", c, mem_re_o, mem_addr_o); end
      n_cmp++; if (mem_wait_i !== (c < 5) || instr_valid_o !== 1'b0) begin n_err++;
        $display("FAIL ws_nopush c%0d: got wait%b valid%b want wait%b valid0", c, mem_wait_i, instr_valid_o, c < 5); end
    end
    @(negedge clk);
    n_cmp++; if (instr_valid_o !== 1'b1 || instr_o !== 16'h0BB6 || mem_re_o !== 1'b0) begin n_err++;
      $display("FAIL ws_capture: got v%b %h re%b want v1 0bb6 re0", instr_valid_o, instr_o, mem_re_o); end
    n_cmp++; if (addr_err != 0) begin n_err++; $display("FAIL ws_addr_stable: got %0d violations want 0", addr_err); end
  endtask

  task automatic test_redirect_mid_req();
    int base;
    bit found = 1'b0;
    @(posedge clk); hold_reset(1'b0, 2); release_reset();
    base = cap_cnt;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (cap_cnt - base == 1 && mem_re_o && !mem_wait_i) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL redir_find_req: got none want second capture cycle"); end
    redirect_i = 1'b1; redirect_addr_i = 16'h0013;
    @(posedge clk); #1 redirect_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_re_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_err++;
      $display("FAIL redir_flush: got re%b valid%b want re0 valid0", mem_re_o, instr_valid_o); end
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (mem_re_o) found = 1'b1;
    end
    n_cmp++; if (!found || mem_addr_o !== 16'h0012) begin n_err++;
      $display("FAIL redir_addr: got re%b addr %h want re1 addr 0012", found, mem_addr_o); end
    collect(2, 40);
    n_cmp++; if (got_pc.size() != 2) begin n_err++; $display("FAIL redir_count: got %0d want 2", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_cmp++; if (got_pc[i] !== 16'(16'h12 + 2 * i) || got_i[i] !== rom_word(16'(16'h12 + 2 * i))) begin n_err++;
        $display("FAIL redir_word %0d: got %h@%h want %h@%h", i, got_i[i], got_pc[i], rom_word(16'(16'h12 + 2 * i)), 16'(16'h12 + 2 * i)); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] e_pc[3] = '{16'hFFFE, 16'h0000, 16'h0002};
    @(posedge clk); hold_reset(1'b1, 1); release_reset();
    redirect_i = 1'b1; redirect_addr_i = 16'hFFFE;
    @(posedge clk); #1 redirect_i = 1'b0;
    collect(3, 60);
    n_cmp++; if (got_pc.size() != 3) begin n_err++; $display("FAIL wrap_count: got %0d want 3", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_cmp++; if (got_pc[i] !== e_pc[i] || got_i[i] !== rom_word(e_pc[i])) begin n_err++;
        $display("FAIL wrap_word %0d: got %h@%h want %h@%h", i, got_i[i], got_pc[i], rom_word(e_pc[i]), e_pc[i]); end
    end
  endtask

  task automatic test_reset_mid_req();
    int base;
    bit found = 1'b0;
    @(posedge clk); hold_reset(1'b0, 3); release_reset();
    base = cap_cnt;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (cap_cnt - base == 1 && mem_re_o) found = 1'b1;
    end
    n_cmp++; if (!found || instr_valid_o !== 1'b1) begin n_err++;
      $display("FAIL rstmid_setup: got found%b valid%b want 1 1", found, instr_valid_o); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (mem_re_o !== 1'b0 || mem_addr_o !== RESET_PC || instr_valid_o !== 1'b0 ||
                 instr_o !== 16'h0 || instr_pc_o !== 16'h0) begin n_err++;
      $display("FAIL rstmid_outputs: got re%b addr %h v%b %h@%h want all reset", mem_re_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o); end
    @(posedge clk); release_reset();
    @(negedge clk);
    n_cmp++; if (mem_re_o !== 1'b1 || mem_addr_o !== RESET_PC) begin n_err++;
      $display("FAIL rstmid_restart: got re%b addr %h want re1 addr %h", mem_re_o, mem_addr_o, RESET_PC); end
    collect(1, 30);
    n_cmp++; if (got_pc.size() != 1 || got_pc[0] !== RESET_PC || got_i[0] !== rom_word(RESET_PC)) begin n_err++;
      $display("FAIL rstmid_first_word: got %0d words want 1 word %h@%h", got_pc.size(), rom_word(RESET_PC), RESET_PC); end
  endtask

  // Model: decoder sees an unbroken +2 pc stream starting at each redirect target.
  task automatic test_random();
    logic [15:0] exp_pc = RESET_PC;
    int pops = 0;
    bit redir_prev = 1'b0;
    rand_wait = 1'b1;
    @(posedge clk); hold_reset(1'b1, 1); release_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      instr_ready_i   = ($urandom_range(0, 3) != 0);
      redirect_i      = ($urandom_range(0, 49) == 0);
      redirect_addr_i = 16'($urandom);
      @(negedge clk);
      if (redir_prev) begin
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rnd_post_redirect cyc%0d: got valid %b want 0", cyc, instr_valid_o); end
      end
      if (instr_valid_o && instr_ready_i) begin
        n_cmp++; if (instr_pc_o !== exp_pc || instr_o !== rom_word(exp_pc)) begin n_err++;
          $display("FAIL rnd_word cyc%0d: got %h@%h want %h@%h", cyc, instr_o, instr_pc_o, rom_word(exp_pc), exp_pc); end
        exp_pc = exp_pc + 16'd2;
        pops++;
      end
      if (redirect_i) exp_pc = {redirect_addr_i[15:1], 1'b0};
      redir_prev = redirect_i;
      @(posedge clk); #1;
    end
    redirect_i = 1'b0;
    rand_wait  = 1'b0;
    n_cmp++; if (pops < 200) begin n_err++; $display("FAIL rnd_throughput: got %0d pops want >= 200", pops); end
    n_cmp++; if (addr_err != 0) begin n_err++; $display("FAIL rnd_addr_stable: got %0d violations want 0", addr_err); end
    n_cmp++; if (gap_err != 0) begin n_err++; $display("FAIL rnd_re_gap: got %0d violations want 0", gap_err); end
  endtask

  initial begin
    rst = 1'b1; redirect_i = 1'b0; redirect_addr_i = '0; instr_ready_i = 1'b1;
    test_reset();
    test_zero_wait();
    test_ready_stall();
    test_wait_states();
    test_redirect_mid_req();
    test_wrap();
    test_reset_mid_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting between the CPU decoder and the instruction memory port (wait-handshake ROM/RAM). Generates sequential word addresses and drives the memory read handshake. Buffers returned instruction words in a small prefetch FIFO with valid/ready to decode. Supports PC redirect (branch/jump) with flush of buffered and in-flight fetches.

Parameters:
RESET_PC, 16'h0000, address of first fetch after reset (bit 0 ignored)
DEPTH, 2, prefetch FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous, active-high reset
mem_addr_o  output  16  memory byte address, bit 0 always 0
mem_re_o  output  1  memory read enable
mem_wait_i  input  1  memory not-ready; valid only while mem_re_o=1
mem_data_i  input  16  read data; valid when mem_re_o=1 and mem_wait_i=0
redirect_i  input  1  load new PC, flush fetch path
redirect_addr_i  input  16  new PC (bit 0 forced to 0)
instr_o  output  16  instruction word at FIFO head
instr_pc_o  output  16  address of instr_o
instr_valid_o  output  1  FIFO non-empty
instr_ready_i  input  1  decoder accepts head this cycle

Behaviour:
- Memory protocol: addr held stable while mem_re_o=1. Response is accepted ("capture") on the posedge where mem_re_o=1 and mem_wait_i=0. After every capture or abort, mem_re_o must be 0 for at least one full cycle before the next request (memory re-arms its ready flag only on a low re cycle).
- FSM states: IDLE (re=0), REQ (re=1, waiting), GAP (re=0, one cycle).
  - IDLE -> REQ when free slots exist: count + 0 < DEPTH (no outstanding when in IDLE).
  - REQ -> GAP on capture: push {mem_data_i, mem_addr_o} into FIFO, fetch_pc += 2.
  - REQ stays while mem_wait_i=1.
  - GAP -> REQ if FIFO would still have a free slot after this cycle's push/pop, else IDLE.
- Minimum fetch cadence with zero-wait-state memory: 3 cycles per word (REQ wait, REQ capture, GAP).
- A request is never launched unless a FIFO slot is guaranteed; a capture therefore never sees a full FIFO.
- fetch_pc wraps 16'hFFFE -> 16'h0000.
- Decode side: instr_valid_o = !empty; pop on instr_valid_o & instr_ready_i. Push and pop in the same cycle are both honoured; count unchanged.
- Redirect (highest priority):
  - FIFO flushed; a same-cycle pop is still considered consumed, and a same-cycle capture is discarded.
  - fetch_pc <= {redirect_addr_i[15:1],1'b0}.
  - If in REQ, re drops next cycle (abort) and the FSM goes to GAP; otherwise it goes to GAP as well (uniform one-cycle bubble).
  - instr_valid_o = 0 in the cycle after redirect.
- Reset (any time, including mid-request): mem_re_o=0, mem_addr_o=RESET_PC&16'hFFFE, FSM=IDLE, FIFO empty, instr_valid_o=0, instr_o/instr_pc_o=0. First cycle after rst deasserts: REQ.

Decomposition:
- Shared cpu package: word width 16, NOP encoding 16'hF000, PC increment 2.
- One sub-module, fetch_fifo: DEPTH x 32-bit sync FIFO (data+pc), registered count, push/pop/flush, combinational head.
- FSM, PC and control live in fetch_unit.

Test Plan:
- Reset release, zero-wait ROM (ROM words 0x0BB6, 0x0102 at addresses 0, 2), instr_ready_i=1 -> re high cycles 0-1, capture at end of cycle 1, instr_valid_o=1 cycle 2 with 0x0BB6/pc 0; next word 0x0102/pc 2 three cycles later.
- instr_ready_i=0 -> exactly DEPTH words fetched (pcs 0, 2), then FSM sits in IDLE with re=0. Raise ready -> words pop in order, and fetch resumes at pc 4.
- Memory holds wait high 5 cycles -> mem_addr_o stable, no push; capture on the first cycle wait=0.
- redirect_i with redirect_addr_i=16'h0013 mid-REQ -> re low next cycle, FIFO empty, in-flight data never appears, next request addr 16'h0012.
- Redirect to 16'hFFFE -> fetches 16'hFFFE then 16'h0000.
- rst asserted during REQ with FIFO holding 1 entry -> next cycle all outputs at reset values, restart from RESET_PC.
